// File: rtl/multitap_pkg.sv
// multitap_pkg: shared types and constants for the multitap sequencer.
// State enum, nibble codes, pad button bit positions, data nibble helper.
package multitap_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TYPE,
    ST_DATA,
    ST_DONE
  } mt_state_t;

  localparam int SEQ_W   = 6;
  localparam int HDR_LEN = 2;

  localparam logic [3:0] NIB_IDLE = 4'h3;
  localparam logic [3:0] NIB_NONE = 4'hF;
  localparam logic [3:0] NIB_HDR  = 4'h0;
  localparam logic [3:0] TYPE_3B  = 4'h0;
  localparam logic [3:0] TYPE_6B  = 4'h1;

  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_A     = 4;
  localparam int B_B     = 5;
  localparam int B_C     = 6;
  localparam int B_START = 7;
  localparam int B_MODE  = 8;
  localparam int B_X     = 9;
  localparam int B_Y     = 10;
  localparam int B_Z     = 11;

  // Pad buttons are active-high; the wire protocol is active-low.
  function automatic logic [3:0] data_nib(
    input logic [11:0] p,
    input int          k
  );
    logic [3:0] n;
    unique case (1'b1)
      (k == 0): n = {p[B_RIGHT], p[B_LEFT], p[B_DOWN], p[B_UP]};
      (k == 1): n = {p[B_START], p[B_A], p[B_C], p[B_B]};
      default:  n = {p[B_MODE], p[B_X], p[B_Y], p[B_Z]};
    endcase
    return ~n;
  endfunction

endpackage

// File: rtl/multitap_nibble_sel.sv
// multitap_nibble_sel: maps frozen pad snapshot plus stream index
// to the nibble to present and a flag marking the final nibble.
module multitap_nibble_sel
  import multitap_pkg::*;
#(
  parameter int NUM_PADS = 4
) (
  input  logic [NUM_PADS*12-1:0] pads_i,
  input  logic [NUM_PADS-1:0]    six_i,
  input  logic [NUM_PADS-1:0]    present_i,
  input  logic [SEQ_W-1:0]       idx_i,
  output logic [3:0]             nib_o,
  output logic                   last_o
);

  int idx;
  int base;
  int len;

  always_comb begin
    nib_o = NIB_NONE;
    idx   = int'(idx_i);
    base  = HDR_LEN + NUM_PADS;
    len   = 0;
    if (idx < HDR_LEN) nib_o = NIB_HDR;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (idx == HDR_LEN + i) begin
        if (!present_i[i])  nib_o = NIB_NONE;
        else if (six_i[i])  nib_o = TYPE_6B;
        else                nib_o = TYPE_3B;
      end
      // Data region: absent pads take zero slots.
      len = present_i[i] ? (six_i[i] ? 3 : 2) : 0;
      for (int k = 0; k < 3; k++) begin
        if (k < len && idx == base + k)
          nib_o = data_nib(pads_i[12*i +: 12], k);
      end
      base = base + len;
    end
    last_o = (idx == base - 1);
  end

endmodule

// File: rtl/multitap_seq.sv
// multitap_seq: Team-Player-style multitap nibble sequencer, 1..8 pads.
// Define MULTITAP_TIMEOUT_EN to abort stalled transfers after TIMEOUT CEs.
module multitap_seq
  import multitap_pkg::*;
#(
  parameter int NUM_PADS = 4,
  parameter int TIMEOUT  = 4096
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   CE,
  input  logic                   TH_IN,
  input  logic                   TR_IN,
  input  logic [NUM_PADS*12-1:0] PADS,
  input  logic [NUM_PADS-1:0]    PAD_6BTN,
  input  logic [NUM_PADS-1:0]    PAD_PRESENT,
  output logic [3:0]             D_OUT,
  output logic                   TL_OUT,
  output logic                   BUSY
);

  mt_state_t state_q, state_d;
  logic [SEQ_W-1:0] idx_q, idx_d, nidx;
  logic [3:0] dout_q, dout_d;
  logic tl_q, tl_d;
  logic th_q, tr_q;
  logic [NUM_PADS*12-1:0] pads_q, pads_d;
  logic [NUM_PADS-1:0] six_q, six_d;
  logic [NUM_PADS-1:0] pres_q, pres_d;

  logic th_fall, th_rise, tr_edge;
  logic [3:0] sel_nib;
  logic sel_last;

  assign th_fall = th_q & ~TH_IN;
  assign th_rise = ~th_q & TH_IN;
  assign tr_edge = tr_q ^ TR_IN;
  assign nidx    = idx_q + 1'b1;

  multitap_nibble_sel #(
    .NUM_PADS (NUM_PADS)
  ) u_sel (
    .pads_i    (pads_q),
    .six_i     (six_q),
    .present_i (pres_q),
    .idx_i     (idx_q),
    .nib_o     (sel_nib),
    .last_o    (sel_last)
  );

`ifdef MULTITAP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dout_d  = dout_q;
    tl_d    = tl_q;
    pads_d  = pads_q;
    six_d   = six_q;
    pres_d  = pres_q;
    if (th_fall) begin
      // TH fall wins over a coincident TR edge.
      pads_d  = PADS;
      six_d   = PAD_6BTN;
      pres_d  = PAD_PRESENT;
      idx_d   = '0;
      state_d = ST_HDR;
      dout_d  = NIB_NONE;
      tl_d    = TR_IN;
    end else if (th_rise) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      dout_d  = NIB_IDLE;
      tl_d    = 1'b1;
    end else if (tr_edge && state_q != ST_IDLE) begin
      tl_d = TR_IN;
      if (state_q == ST_DONE) begin
        dout_d = NIB_NONE;
      end else begin
        dout_d = sel_nib;
        if (sel_last)
          state_d = ST_DONE;
        else begin
          idx_d = nidx;
          if (nidx < SEQ_W'(HDR_LEN))
            state_d = ST_HDR;
          else if (nidx < SEQ_W'(HDR_LEN + NUM_PADS))
            state_d = ST_TYPE;
          else
            state_d = ST_DATA;
        end
      end
    end
`ifdef MULTITAP_TIMEOUT_EN
    cnt_d = '0;
    if (state_q != ST_IDLE && !th_fall && !th_rise && !tr_edge) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        state_d = ST_IDLE;
        idx_d   = '0;
        dout_d  = NIB_IDLE;
        tl_d    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      dout_q  <= NIB_IDLE;
      tl_q    <= 1'b1;
      th_q    <= 1'b1;
      tr_q    <= 1'b1;
      pads_q  <= '0;
      six_q   <= '0;
      pres_q  <= '0;
    end else if (CE) begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dout_q  <= dout_d;
      tl_q    <= tl_d;
      th_q    <= TH_IN;
      tr_q    <= TR_IN;
      pads_q  <= pads_d;
      six_q   <= six_d;
      pres_q  <= pres_d;
    end
  end

`ifdef MULTITAP_TIMEOUT_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N)
      cnt_q <= '0;
    else if (CE)
      cnt_q <= cnt_d;
  end
`endif

  assign D_OUT  = dout_q;
  assign TL_OUT = tl_q;
  assign BUSY   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_multitap_seq.sv
// tb_multitap_seq: directed bench for multitap_seq, NUM_PADS=4.
// TIMEOUT is set to 16 so the optional abort path is short.
module tb_multitap_seq;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        CE;
  logic        TH;
  logic        TR;
  logic [47:0] PADS;
  logic [3:0]  P6;
  logic [3:0]  PP;
  logic [3:0]  D_OUT;
  logic        TL_OUT;
  logic        BUSY;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_a [14];
  logic [3:0] exp_b [13];
  logic [3:0] exp_c [8];
  logic       tl_hold;

  multitap_seq #(
    .NUM_PADS (4),
    .TIMEOUT  (16)
  ) dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .CE          (CE),
    .TH_IN       (TH),
    .TR_IN       (TR),
    .PADS        (PADS),
    .PAD_6BTN    (P6),
    .PAD_PRESENT (PP),
    .D_OUT       (D_OUT),
    .TL_OUT      (TL_OUT),
    .BUSY        (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(
    input string      tag,
    input logic [3:0] obs,
    input logic [3:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  task automatic tog(input string tag, input logic [3:0] e);
    TR = ~TR;
    clk1();
    chk({tag, "_nib"}, D_OUT, e);
    chk({tag, "_tl"}, {3'b0, TL_OUT}, {3'b0, TR});
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_d"}, D_OUT, 4'h3);
    chk({tag, "_tl"}, {3'b0, TL_OUT}, 4'h1);
    chk({tag, "_busy"}, {3'b0, BUSY}, 4'h0);
  endtask

  initial begin
    exp_a = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hE,
              4'hB, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    exp_b = '{4'h0, 4'h0, 4'h0, 4'h1, 4'hF, 4'h0, 4'hF,
              4'hF, 4'h7, 4'hF, 4'hB, 4'hF, 4'hF};
    exp_c = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hD, 4'hF};

    RESET_N = 1'b0;
    CE      = 1'b1;
    TH      = 1'b1;
    TR      = 1'b1;
    PADS    = '0;
    P6      = '0;
    PP      = '0;
    clk1();
    clk1();
    RESET_N = 1'b1;
    clk1();
    idle_chk("reset");

    // All 3-button, pad0 UP+A; pads change mid-transfer.
    PADS = {12'h000, 12'h000, 12'h000, 12'h011};
    PP   = 4'hF;
    TH   = 1'b0;
    clk1();
    chk("a_start_d", D_OUT, 4'hF);
    chk("a_start_tl", {3'b0, TL_OUT}, {3'b0, TR});
    chk("a_busy", {3'b0, BUSY}, 4'h1);
    for (int i = 0; i < 14; i++) begin
      if (i == 4) PADS = {48{1'b1}};
      tog($sformatf("a%0d", i), exp_a[i]);
    end
    tog("a_done", 4'hF);
    tog("a_done2", 4'hF);
    TH = 1'b1;
    clk1();
    idle_chk("a_end");

    // Pad1 6-button X+RIGHT, pad2 absent with buttons held.
    PADS = {12'h000, 12'hFFF, 12'h208, 12'h000};
    P6   = 4'b0010;
    PP   = 4'b1011;
    TH   = 1'b0;
    clk1();
    chk("b_start_d", D_OUT, 4'hF);
    for (int i = 0; i < 13; i++)
      tog($sformatf("b%0d", i), exp_b[i]);
    tog("b_done", 4'hF);
    chk("b_busy", {3'b0, BUSY}, 4'h1);
    TH = 1'b1;
    clk1();
    idle_chk("b_end");

    // Abort after 5 nibbles, then restart with a fresh snapshot.
    PADS = {12'h000, 12'h000, 12'h000, 12'h011};
    P6   = 4'h0;
    PP   = 4'hF;
    TH   = 1'b0;
    clk1();
    for (int i = 0; i < 5; i++)
      tog($sformatf("c_pre%0d", i), 4'h0);
    TH = 1'b1;
    clk1();
    idle_chk("c_abort");
    PADS = {12'h000, 12'h000, 12'h000, 12'h002};
    TH   = 1'b0;
    clk1();
    chk("c_start_d", D_OUT, 4'hF);
    for (int i = 0; i < 8; i++)
      tog($sformatf("c%0d", i), exp_c[i]);
    TH = 1'b1;
    clk1();
    idle_chk("c_end");

    // TH fall together with a TR edge: no extra index advance.
    PADS = '0;
    P6   = 4'b0001;
    TH   = 1'b0;
    TR   = ~TR;
    clk1();
    chk("d_start_d", D_OUT, 4'hF);
    chk("d_busy", {3'b0, BUSY}, 4'h1);
    tog("d0", 4'h0);
    tog("d1", 4'h0);
    tog("d2", 4'h1);

    // CE low holds outputs; the edge is taken once CE returns.
    tl_hold = TL_OUT;
    CE = 1'b0;
    TR = ~TR;
    clk1();
    chk("ce_hold_d", D_OUT, 4'h1);
    chk("ce_hold_tl", {3'b0, TL_OUT}, {3'b0, tl_hold});
    CE = 1'b1;
    clk1();
    chk("ce_resume_d", D_OUT, 4'h0);
    chk("ce_resume_tl", {3'b0, TL_OUT}, {3'b0, TR});
    tog("d4", 4'h0);
    tog("d5", 4'h0);
    tog("d6", 4'hF);

`ifdef MULTITAP_TIMEOUT_EN
    repeat (15) clk1();
    chk("to_before", {3'b0, BUSY}, 4'h1);
    clk1();
    idle_chk("to_fire");
`else
    repeat (1000) clk1();
    chk("no_to_busy", {3'b0, BUSY}, 4'h1);
    chk("no_to_d", D_OUT, 4'hF);
`endif

    // Reset mid-transfer with CE low.
    TH = 1'b1;
    clk1();
    TH = 1'b0;
    clk1();
    tog("r0", 4'h0);
    CE      = 1'b0;
    RESET_N = 1'b0;
    clk1();
    idle_chk("rst_mid");
    RESET_N = 1'b1;
    CE      = 1'b1;
    TH      = 1'b1;
    clk1();
    idle_chk("rst_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
